ecc_scalar_sched: RTL and testbench

Scheduler for GF(2^233) scalar point multiplication on the B-233 datapath. It latches a scalar key, skips leading zeros, then walks the remaining bits MSB-first. For each step it issues INIT, point-double, point-add and projective-to-affine conversion requests to the register-bank/ALU microsequencer over a req/done handshake. It sits between the host-facing top and the microcode unit that drives the register-bank and ALU control words.

---
 rtl/ecc_scalar_sched_pkg.sv | 22 ++
 rtl/ecc_scalar_sched_if.sv | 30 +++
 rtl/ecc_scalar_sched_key_scanner.sv | 52 +++++
 rtl/ecc_scalar_sched.sv | 162 ++++++++++++++++
 tb/tb_ecc_scalar_sched.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_scalar_sched_pkg.sv
// Shared state encoding, op codes and default scalar width for the
// B-233 scalar-multiplication scheduler.
package ecc_sched_pkg;

    localparam int KEY_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_INIT,
        ST_DBL,
        ST_ADD,
        ST_CONV,
        ST_DONE
    } state_e;

    localparam logic [1:0] OP_INIT = 2'd0;
    localparam logic [1:0] OP_DBL  = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;
    localparam logic [1:0] OP_CONV = 2'd3;

endpackage

// File: rtl/ecc_scalar_sched_if.sv
// Host and microsequencer signals of the scalar scheduler; master drives
// start/key/op_done, slave is the scheduler itself.
interface ecc_scalar_sched_if
    import ecc_sched_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) ();
    localparam int IDX_W = $clog2(KEY_W);

    logic             start;
    logic [KEY_W-1:0] key;
    logic             op_done;
    logic             op_req;
    logic [1:0]       op_code;
    logic             add_dummy;
    logic [IDX_W-1:0] bit_idx;
    logic             busy;
    logic             done;
    logic             key_zero;

    modport master (
        output start, key, op_done,
        input  op_req, op_code, add_dummy, bit_idx, busy, done, key_zero
    );

    modport slave (
        input  start, key, op_done,
        output op_req, op_code, add_dummy, bit_idx, busy, done, key_zero
    );
endinterface

// File: rtl/ecc_scalar_sched_key_scanner.sv
// Holds the captured scalar and the MSB-first bit pointer.
// Latency: load/dec take effect at the next edge; flags are combinational from the flops.
// Backpressure: none; the scheduler decides when to load or step.
module ecc_key_scanner
    import ecc_sched_pkg::*;
#(
    parameter  int KEY_W = KEY_W_DEF,
    localparam int IDX_W = $clog2(KEY_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [KEY_W-1:0] key,
    input  logic             dec,
    output logic [IDX_W-1:0] idx,
    output logic             cur_bit,
    output logic             idx_zero,
    output logic             all_zero
);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(KEY_W - 1);

    logic [KEY_W-1:0] key_r_q, key_r_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // The scalar is frozen after capture so the host may reuse its key bus.
    always_comb begin
        key_r_d = key_r_q;
        idx_d   = idx_q;
        if (load) begin
            key_r_d = key;
            idx_d   = IDX_TOP;
        end else if (dec) begin
            idx_d = idx_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_r_q <= '0;
            idx_q   <= IDX_TOP;
        end else begin
            key_r_q <= key_r_d;
            idx_q   <= idx_d;
        end
    end

    assign idx      = idx_q;
    assign cur_bit  = key_r_q[idx_q];
    assign idx_zero = (idx_q == '0);
    assign all_zero = (key_r_q == '0);

endmodule

// File: rtl/ecc_scalar_sched.sv
// Scalar-multiplication scheduler: skips leading zeros, then issues INIT/DBL/ADD/CONV ops MSB-first.
// Latency: first op_req 2+z cycles after start; each op completes on the edge op_done is seen.
// Backpressure: op_req is a level held until op_done; ECC_SCHED_CONST_TIME_EN adds an ADD after every DBL.
module ecc_scalar_sched
    import ecc_sched_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    ecc_scalar_sched_if.slave  bus
);
    localparam int IDX_W = $clog2(KEY_W);

    state_e           state_q, state_d;
    logic             op_req_q, op_req_d;
    logic [1:0]       op_code_q, op_code_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             key_zero_q, key_zero_d;

    logic             scan_load;
    logic             scan_dec;
    logic [IDX_W-1:0] scan_idx;
    logic             cur_bit;
    logic             idx_zero;
    logic             all_zero;

    ecc_key_scanner #(.KEY_W(KEY_W)) u_scan (
        .clk      (clk),
        .reset    (reset),
        .load     (scan_load),
        .key      (bus.key),
        .dec      (scan_dec),
        .idx      (scan_idx),
        .cur_bit  (cur_bit),
        .idx_zero (idx_zero),
        .all_zero (all_zero)
    );

    always_comb begin
        state_d    = state_q;
        key_zero_d = key_zero_q;
        scan_load  = 1'b0;
        scan_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    scan_load  = 1'b1;
                    key_zero_d = 1'b0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cur_bit) begin
                    state_d = ST_INIT;
                end else if (idx_zero) begin
                    key_zero_d = all_zero;
                    state_d    = ST_DONE;
                end else begin
                    scan_dec = 1'b1;
                end
            end
            ST_INIT, ST_ADD: begin
                if (bus.op_done) begin
                    if (idx_zero) begin
                        state_d = ST_CONV;
                    end else begin
                        scan_dec = 1'b1;
                        state_d  = ST_DBL;
                    end
                end
            end
            ST_DBL: begin
                if (bus.op_done) begin
`ifdef ECC_SCHED_CONST_TIME_EN
                    state_d = ST_ADD;
`else
                    if (cur_bit) begin
                        state_d = ST_ADD;
                    end else if (idx_zero) begin
                        state_d = ST_CONV;
                    end else begin
                        scan_dec = 1'b1;
                        state_d  = ST_DBL;
                    end
`endif
                end
            end
            ST_CONV: begin
                if (bus.op_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs follow the next state so op_req/op_code switch on the op_done edge.
        op_req_d = (state_d == ST_INIT) || (state_d == ST_DBL) ||
                   (state_d == ST_ADD)  || (state_d == ST_CONV);
        case (state_d)
            ST_INIT: op_code_d = OP_INIT;
            ST_DBL:  op_code_d = OP_DBL;
            ST_ADD:  op_code_d = OP_ADD;
            ST_CONV: op_code_d = OP_CONV;
            default: op_code_d = op_code_q;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_req_q   <= 1'b0;
            op_code_q  <= OP_INIT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            key_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_req_q   <= op_req_d;
            op_code_q  <= op_code_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            key_zero_q <= key_zero_d;
        end
    end

`ifdef ECC_SCHED_CONST_TIME_EN
    logic add_dummy_q, add_dummy_d;

    // Decided on entry to ADD from the bit DBL just processed, then held.
    always_comb begin
        add_dummy_d = 1'b0;
        if (state_d == ST_ADD) begin
            add_dummy_d = (state_q == ST_ADD) ? add_dummy_q : !cur_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            add_dummy_q <= 1'b0;
        end else begin
            add_dummy_q <= add_dummy_d;
        end
    end

    assign bus.add_dummy = add_dummy_q;
`else
    assign bus.add_dummy = 1'b0;
`endif

    assign bus.op_req   = op_req_q;
    assign bus.op_code  = op_code_q;
    assign bus.bit_idx  = scan_idx;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.key_zero = key_zero_q;

endmodule

// File: tb/tb_ecc_scalar_sched.sv
// Bench for ecc_scalar_sched: expected op lists and cycle timing come from the scalar rules.
module tb_ecc_scalar_sched;
    import ecc_sched_pkg::*;

    localparam int KW = 32;

    typedef struct {
        logic [1:0] code;
        int         idx;
        logic       dummy;
    } op_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ecc_scalar_sched_if #(.KEY_W(KW)) bus();

    ecc_scalar_sched #(.KEY_W(KW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;
    int   mode;            // 0 idle, 1 job running, 2 reset pending
    int   job_n, req_from, done_cyc, rst_check_cyc, obs_done_cyc;
    logic exp_kz, last_kz;
    int   dly_min, dly_max;
    logic spurious;
    op_t  exp_ops[$];
    op_t  obs[$];

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected op list from the scalar: INIT at the top set bit, then DBL (+ADD) per lower bit, then CONV.
    function automatic int build_model(input logic [KW-1:0] k);
        int t = -1;
        exp_ops.delete();
        for (int i = 0; i < KW; i++) if (k[i]) t = i;
        if (t < 0) return t;
        exp_ops.push_back('{OP_INIT, t, 1'b0});
        for (int i = t - 1; i >= 0; i--) begin
            exp_ops.push_back('{OP_DBL, i, 1'b0});
`ifdef ECC_SCHED_CONST_TIME_EN
            exp_ops.push_back('{OP_ADD, i, !k[i]});
`else
            if (k[i]) exp_ops.push_back('{OP_ADD, i, 1'b0});
`endif
        end
        exp_ops.push_back('{OP_CONV, 0, 1'b0});
        return t;
    endfunction

    // Microsequencer stand-in: answers each op after a random number of cycles.
    initial begin
        int  cnt, target;
        bit  waiting;
        bus.op_done = 1'b0;
        waiting = 0; cnt = 0; target = 0;
        forever begin
            @(posedge clk); #1;
            bus.op_done = spurious;
            if (bus.op_req === 1'b1) begin
                if (!waiting) begin
                    target  = $urandom_range(dly_max, dly_min);
                    cnt     = 0;
                    waiting = 1;
                end
                if (cnt == target) begin
                    bus.op_done = 1'b1;
                    waiting     = 0;
                end else begin
                    cnt++;
                end
            end else begin
                waiting = 0;
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the model's expectations.
    always @(negedge clk) begin
        int c, sidx;
        bit in_ops;
        c = ecnt;
        if (mode == 2) begin
            if (c == rst_check_cyc) begin
                chk("rst_op_req",    bus.op_req,    0);
                chk("rst_op_code",   bus.op_code,   0);
                chk("rst_add_dummy", bus.add_dummy, 0);
                chk("rst_bit_idx",   bus.bit_idx,   KW - 1);
                chk("rst_busy",      bus.busy,      0);
                chk("rst_done",      bus.done,      0);
                chk("rst_key_zero",  bus.key_zero,  0);
                last_kz = 1'b0;
                mode = 0;
            end
        end else if (mode == 1 && c >= job_n) begin
            sidx = KW - 1 - (c - job_n);
            if (sidx < 0) sidx = 0;
            in_ops = (c >= req_from) && (exp_ops.size() > 0);
            if (c == done_cyc) begin
                chk("done_pulse",    bus.done,     1);
                chk("done_op_req",   bus.op_req,   0);
                chk("done_key_zero", bus.key_zero, exp_kz);
                obs_done_cyc = c;
                last_kz = exp_kz;
                mode = 0;
            end else if (in_ops) begin
                chk("op_req",     bus.op_req,    1);
                chk("op_code",    bus.op_code,   exp_ops[0].code);
                chk("op_bit_idx", bus.bit_idx,   exp_ops[0].idx);
                chk("add_dummy",  bus.add_dummy, exp_ops[0].dummy);
                chk("op_busy",    bus.busy,      1);
                chk("op_done_lo", bus.done,      0);
                chk("op_kz",      bus.key_zero,  0);
                if (bus.op_done === 1'b1) begin
                    obs.push_back('{bus.op_code, int'(bus.bit_idx), bus.add_dummy});
                    void'(exp_ops.pop_front());
                    if (exp_ops.size() == 0) done_cyc = c + 2;
                end
            end else begin
                chk("scan_op_req",  bus.op_req, 0);
                chk("scan_done",    bus.done,   0);
                chk("scan_busy",    bus.busy,   1);
                chk("scan_bit_idx", bus.bit_idx, (c < req_from) ? sidx : 0);
            end
        end else begin
            chk("idle_op_req",   bus.op_req,   0);
            chk("idle_done",     bus.done,     0);
            chk("idle_busy",     bus.busy,     0);
            chk("idle_key_zero", bus.key_zero, last_kz);
        end
    end

    task automatic arm_job(input logic [KW-1:0] k, input int dmin, input int dmax);
        int t;
        dly_min = dmin;
        dly_max = dmax;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.key   = k;
        t = build_model(k);
        obs.delete();
        job_n    = ecnt + 1;
        req_from = (t < 0) ? 32'h7fff_ffff : job_n + 1 + (KW - 1 - t);
        done_cyc = (t < 0) ? job_n + KW + 1 : 32'h7fff_ffff;
        exp_kz   = (t < 0);
        mode     = 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.key   = $urandom;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.key   = $urandom;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_job(input logic [KW-1:0] k, input int dmin, input int dmax, input bit pulse);
        int n;
        arm_job(k, dmin, dmax);
        if (pulse) begin
            repeat (4) @(posedge clk);
            pulse_start();
            repeat (35) @(posedge clk);
            pulse_start();
        end
        n = 0;
        while (mode == 1 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("job_timeout", (mode == 1), 0);
        if (mode == 1) mode = 0;
        #1;
    endtask

    task automatic pin_ops(input string nm, input int n, input int codes[8],
                           input int idxs[8], input int dums[8]);
        chk({nm, "_len"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++) begin
            chk($sformatf("%s_code%0d", nm, i),  obs[i].code,  codes[i]);
            chk($sformatf("%s_idx%0d", nm, i),   obs[i].idx,   idxs[i]);
            chk($sformatf("%s_dummy%0d", nm, i), obs[i].dummy, dums[i]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cnt_add, cnt_dbl, t, h;
        logic [KW-1:0] k;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.key = '0;
        spurious = 1'b0;
        last_kz = 1'b0;
        dly_min = 0;
        dly_max = 0;
        rst_check_cyc = 1;
        mode = 2;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Spurious op_done in IDLE must do nothing.
        #1 spurious = 1'b1;
        repeat (3) @(posedge clk);
        #1 spurious = 1'b0;
        repeat (2) @(posedge clk);

        run_job(32'h5, 0, 0, 0);
`ifdef ECC_SCHED_CONST_TIME_EN
        pin_ops("key5", 6, '{0, 1, 2, 1, 2, 3, 0, 0}, '{2, 1, 1, 0, 0, 0, 0, 0},
                '{0, 0, 1, 0, 0, 0, 0, 0});
`else
        pin_ops("key5", 5, '{0, 1, 1, 2, 3, 0, 0, 0}, '{2, 1, 0, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0});
`endif

        run_job(32'h0, 0, 0, 0);
        chk("zero_ops", obs.size(), 0);
        chk("zero_done_latency", obs_done_cyc + 1 - job_n, 34);
        chk("zero_key_zero_held", bus.key_zero, 1);

        run_job(32'h8000_0000, 0, 2, 0);
        cnt_add = 0; cnt_dbl = 0;
        foreach (obs[i]) begin
            if (obs[i].code == OP_ADD) cnt_add++;
            if (obs[i].code == OP_DBL) cnt_dbl++;
        end
        chk("msb_dbl_count", cnt_dbl, 31);
`ifdef ECC_SCHED_CONST_TIME_EN
        chk("msb_add_count", cnt_add, 31);
`else
        chk("msb_add_count", cnt_add, 0);
`endif

        run_job(32'h3, 10, 10, 1);
        pin_ops("key3", 4, '{0, 1, 2, 3, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0});

        // Abort during the second DBL of key 0xF.
        arm_job(32'hF, 1, 1);
        n = 0;
        while (obs.size() < 3 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reached_dbl2", (obs.size() >= 3), 1);
        reset = 1'b0;
        mode = 2;
        rst_check_cyc = ecnt + 1;
        exp_ops.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        run_job(32'h1, 0, 1, 0);
        pin_ops("key1", 2, '{0, 3, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0, 0, 0});

        // Random keys with random leading-zero counts and op latencies.
        for (int j = 0; j < 12; j++) begin
            k = $urandom;
            k = k >> $urandom_range(31, 0);
            run_job(k, 0, 3, 0);
            t = -1;
            for (int i = 0; i < KW; i++) if (k[i]) t = i;
            h = $countones(k);
            if (t >= 0) begin
`ifdef ECC_SCHED_CONST_TIME_EN
                chk("rand_op_count", obs.size(), 2 + 2 * t);
`else
                chk("rand_op_count", obs.size(), 1 + t + (h - 1) + 1);
`endif
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
